// File: rtl/bp_me_cache_dma_responder.sv
// ============================================================================
// Module   : bp_me_cache_dma_responder
// Brief    : Memory-side DMA responder for the L2; serves block reads/writes
//            against a single-port synchronous-read SRAM.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bp_me_cache_dma_responder #(
    parameter int daddr_width_p    = 32,
    parameter int fill_width_p     = 64,
    parameter int block_width_p    = 512,
    parameter int mem_addr_width_p = 20,
    localparam int dma_pkt_width_lp = 1 + daddr_width_p
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,

    input  logic [dma_pkt_width_lp-1:0] dma_pkt_i,
    input  logic                        dma_pkt_v_i,
    output logic                        dma_pkt_yumi_o,

    output logic [fill_width_p-1:0]     dma_data_o,
    output logic                        dma_data_v_o,
    input  logic                        dma_data_ready_and_i,

    input  logic [fill_width_p-1:0]     dma_data_i,
    input  logic                        dma_data_v_i,
    output logic                        dma_data_yumi_o,

    output logic                        mem_v_o,
    output logic                        mem_w_o,
    output logic [mem_addr_width_p-1:0] mem_addr_o,
    output logic [fill_width_p-1:0]     mem_data_o,
    input  logic [fill_width_p-1:0]     mem_data_i
);

    localparam int c_beats    = block_width_p / fill_width_p;
    localparam int c_cnt_w    = $clog2(c_beats);
    localparam int c_byte_off = $clog2(fill_width_p / 8);

    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_beats - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [mem_addr_width_p-1:0] c_align_mask = ~mem_addr_width_p'(c_beats - 1);

    typedef enum logic [1:0] {
        e_ready      = 2'd0,
        e_read       = 2'd1,
        e_read_drain = 2'd2,
        e_write      = 2'd3
    } state_e;

    state_e                      r_state;
    state_e                      w_state_next;
    logic [c_cnt_w-1:0]          r_cnt;
    logic [c_cnt_w-1:0]          w_cnt_next;
    logic [mem_addr_width_p-1:0] r_base;
    logic [mem_addr_width_p-1:0] w_pkt_word;
    logic [mem_addr_width_p-1:0] w_pkt_base;
    logic                        r_inflight;

    logic [fill_width_p-1:0]     r_fifo_mem [2];
    logic [1:0]                  r_count;
    logic [1:0]                  w_count_next;
    logic                        r_rptr;
    logic                        r_wptr;
    logic                        w_fifo_empty;
    logic                        w_out_v;
    logic                        w_deq;
    logic                        w_push;
    logic                        w_pop;
    logic [1:0]                  w_occ_after;
    logic                        w_credit;

    logic                        w_mem_v;
    logic                        w_mem_w;

    // Block-aligned SRAM word address; bits above the SRAM range drop off.
    assign w_pkt_word = mem_addr_width_p'(dma_pkt_i[daddr_width_p-1:0] >> c_byte_off);
    assign w_pkt_base = w_pkt_word & c_align_mask;

    // Output head bypasses the FIFO when it is empty so read data can leave
    // the cycle it returns from the SRAM.
    assign w_fifo_empty = (r_count == 2'd0);
    assign w_out_v      = !w_fifo_empty || r_inflight;
    assign w_deq        = w_out_v && dma_data_ready_and_i;
    assign w_pop        = w_deq && !w_fifo_empty;
    assign w_push       = r_inflight && !(w_fifo_empty && dma_data_ready_and_i);

    assign w_occ_after  = r_count + {1'b0, r_inflight} - {1'b0, w_deq};
    assign w_credit     = (w_occ_after < 2'd2);

    assign dma_data_v_o = w_out_v;
    assign dma_data_o   = !w_out_v     ? '0
                        : w_fifo_empty ? mem_data_i
                        :                r_fifo_mem[r_rptr];

    assign mem_v_o    = w_mem_v;
    assign mem_w_o    = w_mem_w;
    assign mem_addr_o = w_mem_v ? (r_base + mem_addr_width_p'(r_cnt)) : '0;
    assign mem_data_o = (w_mem_v && w_mem_w) ? dma_data_i : '0;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 2'd1;
            2'b01:   w_count_next = r_count - 2'd1;
            default: w_count_next = r_count;
        endcase
    end

    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        dma_pkt_yumi_o  = 1'b0;
        dma_data_yumi_o = 1'b0;
        w_mem_v         = 1'b0;
        w_mem_w         = 1'b0;
        case (r_state)
            e_ready: begin
                dma_pkt_yumi_o = dma_pkt_v_i && reset_n_i;
                if (dma_pkt_yumi_o) begin
                    w_cnt_next   = '0;
                    w_state_next = dma_pkt_i[dma_pkt_width_lp-1] ? e_write : e_read;
                end
            end
            e_read: begin
                if (w_credit) begin
                    w_mem_v    = 1'b1;
                    w_cnt_next = r_cnt + c_cnt_one;
                    if (r_cnt == c_cnt_last) begin
                        w_state_next = e_read_drain;
                    end
                end
            end
            e_read_drain: begin
                if (w_occ_after == 2'd0) begin
                    w_state_next = e_ready;
                end
            end
            e_write: begin
                dma_data_yumi_o = dma_data_v_i;
                if (dma_data_v_i) begin
                    w_mem_v    = 1'b1;
                    w_mem_w    = 1'b1;
                    w_cnt_next = r_cnt + c_cnt_one;
                    if (r_cnt == c_cnt_last) begin
                        w_state_next = e_ready;
                    end
                end
            end
            default: w_state_next = e_ready;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state    <= e_ready;
            r_cnt      <= '0;
            r_base     <= '0;
            r_inflight <= 1'b0;
            r_count    <= 2'd0;
            r_rptr     <= 1'b0;
            r_wptr     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_inflight <= w_mem_v && !w_mem_w;
            r_count    <= w_count_next;
            if (dma_pkt_yumi_o) begin
                r_base <= w_pkt_base;
            end
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo_mem[r_wptr] <= mem_data_i;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bp_me_cache_dma_responder.sv
// ============================================================================
// Module   : tb_bp_me_cache_dma_responder
// Brief    : Scoreboard bench for bp_me_cache_dma_responder with SRAM model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bp_me_cache_dma_responder;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic [32:0] dma_pkt_i;
    logic        dma_pkt_v_i;
    logic        dma_pkt_yumi_o;
    logic [63:0] dma_data_o;
    logic        dma_data_v_o;
    logic        dma_data_ready_and_i;
    logic [63:0] dma_data_i;
    logic        dma_data_v_i;
    logic        dma_data_yumi_o;
    logic        mem_v_o;
    logic        mem_w_o;
    logic [19:0] mem_addr_o;
    logic [63:0] mem_data_o;
    logic [63:0] mem_data_i;

    always #5 clk_i = ~clk_i;

    bp_me_cache_dma_responder #(
        .daddr_width_p    (32),
        .fill_width_p     (64),
        .block_width_p    (512),
        .mem_addr_width_p (20)
    ) dut (
        .clk_i                (clk_i),
        .reset_n_i            (reset_n_i),
        .dma_pkt_i            (dma_pkt_i),
        .dma_pkt_v_i          (dma_pkt_v_i),
        .dma_pkt_yumi_o       (dma_pkt_yumi_o),
        .dma_data_o           (dma_data_o),
        .dma_data_v_o         (dma_data_v_o),
        .dma_data_ready_and_i (dma_data_ready_and_i),
        .dma_data_i           (dma_data_i),
        .dma_data_v_i         (dma_data_v_i),
        .dma_data_yumi_o      (dma_data_yumi_o),
        .mem_v_o              (mem_v_o),
        .mem_w_o              (mem_w_o),
        .mem_addr_o           (mem_addr_o),
        .mem_data_o           (mem_data_o),
        .mem_data_i           (mem_data_i)
    );

    // Synchronous-read SRAM model
    logic [63:0] sram [0:(1<<20)-1];
    always @(posedge clk_i) begin
        if (mem_v_o) begin
            if (mem_w_o) sram[mem_addr_o] <= mem_data_o;
            else         mem_data_i       <= sram[mem_addr_o];
        end
    end

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] exp_q[$];
    int          xfer_cyc[$];
    logic [19:0] rd_addr_q[$];
    int          outstanding = 0;
    int          max_out = 0;
    int          n_xfer = 0;
    bit          ready_mode = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    // Ready driver: constant high, or the 1,0,0,1 backpressure pattern
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            dma_data_ready_and_i = ready_mode ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every beat transfer
    initial begin
        logic        prev_stall;
        logic [63:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk_i);
            if (!reset_n_i) begin
                outstanding = 0;
                prev_stall  = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 64'(dma_data_v_o), 64'd1);
                    check("hold_data", dma_data_o, prev_data);
                end
                if (mem_v_o && !mem_w_o) begin
                    rd_addr_q.push_back(mem_addr_o);
                    outstanding++;
                end
                if (dma_data_v_o && dma_data_ready_and_i) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_beat: got 0x%0h, no beat expected", dma_data_o);
                    end else begin
                        check("beat", dma_data_o, exp_q.pop_front());
                    end
                    xfer_cyc.push_back(cyc);
                    n_xfer++;
                    outstanding--;
                end
                if (outstanding > max_out) max_out = outstanding;
                prev_stall = dma_data_v_o && !dma_data_ready_and_i;
                prev_data  = dma_data_o;
            end
        end
    end

    task automatic send_pkt(input logic w, input logic [31:0] a, output int t);
        int k;
        t = -1;
        @(posedge clk_i);
        #1;
        dma_pkt_i   = {w, a};
        dma_pkt_v_i = 1'b1;
        for (k = 0; k < 200; k++) begin
            @(negedge clk_i);
            if (dma_pkt_yumi_o) break;
        end
        if (k == 200) fail_timeout("pkt_yumi");
        else t = cyc;
        @(posedge clk_i);
        #1;
        dma_pkt_v_i = 1'b0;
    endtask

    task automatic write_block(input logic [31:0] a, input logic [63:0] v0, input bit gap,
                               output int t_acc, output int t_first, output int t_last);
        int k;
        send_pkt(1'b1, a, t_acc);
        t_first = -1;
        t_last  = -1;
        for (int i = 0; i < 8; i++) begin
            dma_data_v_i = 1'b1;
            dma_data_i   = v0 + 64'(i);
            for (k = 0; k < 100; k++) begin
                @(negedge clk_i);
                if (dma_data_yumi_o) break;
            end
            if (k == 100) fail_timeout("data_yumi");
            if (i == 0) t_first = cyc;
            if (i == 7) t_last  = cyc;
            @(posedge clk_i);
            #1;
            dma_data_v_i = 1'b0;
            dma_data_i   = '0;
            if (gap && i == 3) begin
                repeat (2) begin
                    @(negedge clk_i);
                    check("gap_mem_v", 64'(mem_v_o), 64'd0);
                    @(posedge clk_i);
                    #1;
                end
            end
        end
    endtask

    task automatic push_block(input logic [63:0] v0);
        for (int i = 0; i < 8; i++) exp_q.push_back(v0 + 64'(i));
    endtask

    task automatic wait_done();
        int k;
        for (k = 0; k < 500; k++) begin
            @(negedge clk_i);
            if (exp_q.size() == 0) break;
        end
        if (k == 500) begin
            fail_timeout("read_done");
            exp_q.delete();
        end
        repeat (3) @(posedge clk_i);
        #1;
    endtask

    task automatic clear_logs();
        xfer_cyc.delete();
        rd_addr_q.delete();
        max_out = 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_pkt_yumi"},  64'(dma_pkt_yumi_o),  64'd0);
        check({tag, "_data_v"},    64'(dma_data_v_o),    64'd0);
        check({tag, "_data_yumi"}, 64'(dma_data_yumi_o), 64'd0);
        check({tag, "_mem_v"},     64'(mem_v_o),         64'd0);
        check({tag, "_mem_w"},     64'(mem_w_o),         64'd0);
        check({tag, "_mem_addr"},  64'(mem_addr_o),      64'd0);
        check({tag, "_mem_data"},  mem_data_o,           64'd0);
        check({tag, "_data_o"},    dma_data_o,           64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int t1, t2, tf, tl;
        int k;
        reset_n_i            = 1'b0;
        dma_pkt_i            = {1'b0, 32'h200};
        dma_pkt_v_i          = 1'b1;
        dma_data_i           = 64'hDEAD_BEEF;
        dma_data_v_i         = 1'b1;
        dma_data_ready_and_i = 1'b1;
        #3;
        check_outputs_zero("reset");
        dma_pkt_v_i  = 1'b0;
        dma_data_v_i = 1'b0;
        dma_data_i   = '0;
        repeat (2) @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;

        // Write block B at byte 0x1C0 (words 0x38-0x3F) with a gap after beat 3
        write_block(32'h1C0, 64'hB0, 1'b1, t1, tf, tl);
        check("wr_first_yumi_cycle", 64'(tf), 64'(t1 + 1));
        check("wr_last_yumi_cycle", 64'(tl), 64'(t1 + 10));
        for (int i = 0; i < 8; i++) check("sram_B", sram[20'h38 + 20'(i)], 64'hB0 + 64'(i));

        // Write block A at byte 0x200 (words 0x40-0x47), continuous
        write_block(32'h200, 64'hA0, 1'b0, t1, tf, tl);
        check("wr2_last_yumi_cycle", 64'(tl), 64'(t1 + 8));
        check("sram_A0", sram[20'h40], 64'hA0);
        check("sram_A7", sram[20'h47], 64'hA7);

        // Read 0x200 with ready high; unaligned 0x21C held valid while busy
        clear_logs();
        push_block(64'hA0);
        push_block(64'hA0);
        send_pkt(1'b0, 32'h200, t1);
        send_pkt(1'b0, 32'h21C, t2);
        wait_done();
        check("busy_pkt_yumi_cycle", 64'(t2), 64'(t1 + 10));
        check("rd_xfer_count", 64'(xfer_cyc.size()), 64'd16);
        check("rd_issue_count", 64'(rd_addr_q.size()), 64'd16);
        if (xfer_cyc.size() >= 8) begin
            check("rd_first_beat_cycle", 64'(xfer_cyc[0]), 64'(t1 + 2));
            check("rd_last_beat_cycle", 64'(xfer_cyc[7]), 64'(t1 + 9));
        end
        if (rd_addr_q.size() >= 9) begin
            check("rd_first_addr", 64'(rd_addr_q[0]), 64'h40);
            check("rd_unaligned_addr", 64'(rd_addr_q[8]), 64'h40);
        end

        // Backpressure: ready toggles 1,0,0,1
        clear_logs();
        ready_mode = 1'b1;
        push_block(64'hB0);
        send_pkt(1'b0, 32'h1C0, t1);
        wait_done();
        ready_mode = 1'b0;
        check("bp_xfer_count", 64'(xfer_cyc.size()), 64'd8);
        check("bp_max_outstanding_le2", 64'(max_out <= 2), 64'd1);
        if (rd_addr_q.size() >= 1) check("bp_first_addr", 64'(rd_addr_q[0]), 64'h38);

        // Address beyond the SRAM range wraps: word 0x100040 -> 0x40
        clear_logs();
        push_block(64'hA0);
        send_pkt(1'b0, 32'h0080_0200, t1);
        wait_done();
        check("wrap_xfer_count", 64'(xfer_cyc.size()), 64'd8);
        if (rd_addr_q.size() >= 1) check("wrap_first_addr", 64'(rd_addr_q[0]), 64'h40);

        // Reset in the middle of a read
        clear_logs();
        push_block(64'hB0);
        n_xfer = 0;
        send_pkt(1'b0, 32'h1C0, t1);
        for (k = 0; k < 100; k++) begin
            @(negedge clk_i);
            if (n_xfer >= 3) break;
        end
        if (k == 100) fail_timeout("mid_read_beat3");
        #1;
        reset_n_i   = 1'b0;
        dma_pkt_v_i = 1'b1;
        #1;
        check_outputs_zero("midrst");
        exp_q.delete();
        repeat (2) @(posedge clk_i);
        #1;
        dma_pkt_v_i = 1'b0;
        reset_n_i   = 1'b1;

        clear_logs();
        push_block(64'hA0);
        send_pkt(1'b0, 32'h200, t1);
        wait_done();
        check("post_rst_xfer_count", 64'(xfer_cyc.size()), 64'd8);
        if (xfer_cyc.size() >= 1) check("post_rst_first_beat_cycle", 64'(xfer_cyc[0]), 64'(t1 + 2));
        if (rd_addr_q.size() >= 1) check("post_rst_first_addr", 64'(rd_addr_q[0]), 64'h40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bp_me_cache_dma_responder.md
# bp_me_cache_dma_responder

Memory-side responder for the L2 cache's DMA channel. It accepts block DMA packets from the L2, then services them against a single-port synchronous-read SRAM. Reads stream fill-width beats back to the cache; writes absorb beats from the cache and commit them to SRAM. It sits directly below the L2 in unicore and simulation configurations that have no off-chip DRAM controller.

## Interface
- daddr_width_p, 32: DMA byte-address width.
- fill_width_p, 64: beat width on the DMA data channels and SRAM data width.
- block_width_p, 512: bits per DMA transaction; `block_width_p/fill_width_p` beats (N, power of two, ≥2).
- mem_addr_width_p, 20: SRAM word-address width.
- dma_pkt_width_lp, 1+daddr_width_p: packet is {write_not_read (MSB), addr}.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- dma_pkt_i  in  dma_pkt_width_lp  DMA command.
- dma_pkt_v_i  in  1  command valid.
- dma_pkt_yumi_o  out  1  command consumed.
- dma_data_o  out  fill_width_p  read beat to cache.
- dma_data_v_o  out  1  read beat valid.
- dma_data_ready_and_i  in  1  cache accepts beat (valid & ready = transfer).
- dma_data_i  in  fill_width_p  write beat from cache.
- dma_data_v_i  in  1  write beat valid.
- dma_data_yumi_o  out  1  write beat consumed.
- mem_v_o  out  1  SRAM access enable.
- mem_w_o  out  1  SRAM write (1) / read (0).
- mem_addr_o  out  mem_addr_width_p  SRAM word address.
- mem_data_o  out  fill_width_p  SRAM write data.
- mem_data_i  in  fill_width_p  SRAM read data, valid the cycle after a read enable.

## Operation
- States: e_ready, e_read, e_read_drain, e_write.
- **e_ready**
  - `dma_pkt_yumi_o = dma_pkt_v_i`. This path is combinational from valid.
  - On accept, latch the base word address: `addr >> log2(fill_width_p/8)`, with the low log2(N) bits forced to 0, truncated to mem_addr_width_p. Out-of-range addresses wrap.
  - Clear the beat counter.
  - Go to e_write if write_not_read=1, otherwise to e_read.
- **e_read**
  - Issue `mem_v_o=1, mem_w_o=0, mem_addr_o = base + cnt` whenever credit is available.
  - Credit is available when (FIFO occupancy + reads in flight − dequeue this cycle) < 2.
  - Returned data enters a 2-entry output FIFO; `dma_data_o` and `dma_data_v_o` are driven from the FIFO head.
  - When the beat with cnt = N−1 is issued, go to e_read_drain.
- **e_read_drain**
  - Issue no SRAM accesses.
  - Return to e_ready once the FIFO is empty and no read is in flight.
- **e_write**
  - `dma_data_yumi_o = dma_data_v_i`.
  - Each yumi drives `mem_v_o=1, mem_w_o=1, mem_addr_o = base + cnt, mem_data_o = dma_data_i` in the same cycle, then increments cnt.
  - The yumi with cnt = N−1 returns the block to e_ready.
- Outside their own states, `dma_pkt_yumi_o` and `dma_data_yumi_o` are 0.
- Only one packet is outstanding at a time; no new packet is accepted until drain completes.
- Counter width is log2(N). `base + cnt` never carries, because base is block-aligned.

## Timing
- Reset (async assert, sync deassert):
  - State goes to e_ready; counter, FIFO and in-flight flag are cleared.
  - All outputs are 0: dma_pkt_yumi_o, dma_data_v_o, dma_data_yumi_o, mem_v_o, mem_w_o, mem_addr_o, mem_data_o. dma_data_o reads 0.
  - Reset mid-transaction aborts it. Buffered beats are discarded and partially written blocks stay partially written.
- Read latency:
  - Packet accepted in cycle t.
  - First SRAM read in t+1.
  - First `dma_data_v_o` in t+2.
  - With ready held high, one beat per cycle: the last beat is valid in t+N+1, and the block is back in e_ready in t+N+2.
- Backpressure:
  - `dma_data_v_o` and `dma_data_o` stay stable until transfer.
  - With ready low, at most 2 reads are issued before stalling; no beat is lost or duplicated.
- Write:
  - First yumi possible in t+1.
  - N beats take N cycles when valid is continuous.
  - Gaps in `dma_data_v_i` insert idle cycles with `mem_v_o=0`.
- `dma_pkt_v_i` arriving during a busy state is held (no yumi) until e_ready.
- `mem_v_o` never asserts in e_ready or e_read_drain.

## Test plan
- Read, no stall:
  - Stimulus: preload SRAM words 0x40–0x47 with 0xA0..0xA7; send pkt {0, 0x200} with N=8; hold ready high.
  - Required: beats 0xA0..0xA7 in order on cycles t+2..t+9; return to e_ready at t+10.
- Write:
  - Stimulus: pkt {1, 0x1C0}; send 8 beats 0xB0..0xB7 with a 2-cycle valid gap after beat 3.
  - Required: SRAM words 0x38–0x3F hold 0xB0..0xB7; mem_v_o is low during the gap.
- Read backpressure:
  - Stimulus: ready toggles 1,0,0,1 repeating.
  - Required: all 8 beats delivered exactly once and in order; never more than 2 outstanding.
- Unaligned and wrapping address:
  - Stimulus: pkt read at 0x21C.
  - Required: reads start at word 0x40, the low bits are ignored.
  - Stimulus: address beyond 2^mem_addr_width_p words.
  - Required: the access wraps.
- Packet during busy:
  - Stimulus: second pkt held valid during a read.
  - Required: yumi is seen only in the cycle after drain completes.
- Reset mid-read:
  - Stimulus: assert reset_n_i=0 at beat 3.
  - Required: all outputs go to 0 immediately; after release, a new read pkt is serviced correctly from beat 0.
